// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter.
package dmem_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_arb_state_t;

    typedef logic mst_id_t;
    localparam mst_id_t M0 = 1'b0;
    localparam mst_id_t M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: the prio holder wins a tie, a lone requester always wins.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_id_t    prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[0] && (prio == M0 || !req[1])) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between two masters; one non-pipelined access per IDLE/ACCESS/RESP pass.
// Optional DMEM_ALIGN_CHECK_EN: misaligned requests skip memory and return an error response.
module dmem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic              m0_err,
    output logic              m1_err,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataW,
    output logic              mem_memR,
    output logic              mem_memW,
    input  logic [DATA_W-1:0] mem_dataR
);
    import dmem_arb_pkg::*;

    dmem_arb_state_t   state_q, state_d;
    mst_id_t           prio_q, prio_d;
    mst_id_t           id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
    logic              err_q, err_d;
`endif

    logic [1:0]        grant;
    logic [1:0]        gnt_vec;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rsp_live;

    rr_arb2 u_rr_arb2 (
        .req   ({m1_req, m0_req}),
        .prio  (prio_q),
        .grant (grant)
    );

    // Grants only leave the arbiter in IDLE, and never while reset is held.
    assign gnt_vec   = (state_q == IDLE && !rst) ? grant : 2'b00;
    assign sel_we    = gnt_vec[1] ? m1_we    : m0_we;
    assign sel_addr  = gnt_vec[1] ? m1_addr  : m0_addr;
    assign sel_wdata = gnt_vec[1] ? m1_wdata : m0_wdata;

    assign m0_gnt = gnt_vec[0];
    assign m1_gnt = gnt_vec[1];

    assign rsp_live  = (state_q == RESP) && !rst;
    assign m0_rvalid = rsp_live && (id_q == M0);
    assign m1_rvalid = rsp_live && (id_q == M1);
    assign m0_rdata  = m0_rvalid ? rdata_q : '0;
    assign m1_rdata  = m1_rvalid ? rdata_q : '0;
`ifdef DMEM_ALIGN_CHECK_EN
    assign m0_err    = m0_rvalid && err_q;
    assign m1_err    = m1_rvalid && err_q;
`endif

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        err_d     = err_q;
`endif
        mem_addr  = '0;
        mem_dataW = '0;
        mem_memR  = 1'b0;
        mem_memW  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|gnt_vec) begin
                    id_d    = gnt_vec[1];
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    rdata_d = '0;
                    state_d = ACCESS;
`ifdef DMEM_ALIGN_CHECK_EN
                    err_d = (sel_addr[1:0] != 2'b00);
                    if (sel_addr[1:0] != 2'b00) begin
                        state_d = RESP;
                    end
`endif
                end
            end
            ACCESS: begin
                mem_addr  = addr_q;
                mem_dataW = wdata_q;
                // Strobes are gated so a reset landing here never commits a write.
                mem_memR  = !we_q && !rst;
                mem_memW  = we_q && !rst;
                rdata_d   = we_q ? '0 : mem_dataR;
                state_d   = RESP;
            end
            RESP: begin
                prio_d  = ~id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= M0;
            id_q    <= M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory behind the port, transaction-level model with a shadow memory.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 12;
    localparam int MEM_SIZE = 1 << ADDR_W;

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [11:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [11:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        m0_err, m1_err;
`endif
    logic [11:0] mem_addr;
    logic [31:0] mem_dataW, mem_dataR;
    logic        mem_memR, mem_memW;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
`ifdef DMEM_ALIGN_CHECK_EN
        .m0_err    (m0_err),
        .m1_err    (m1_err),
`endif
        .mem_addr  (mem_addr),
        .mem_dataW (mem_dataW),
        .mem_memR  (mem_memR),
        .mem_memW  (mem_memW),
        .mem_dataR (mem_dataR)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Memory attached to the port: combinational read, write at the clock edge, wrapping addresses.
    logic [7:0] mem [0:MEM_SIZE-1];
    bit         mem_ready = 1'b0;

    always_comb begin
        mem_dataR = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                     mem[mem_addr + 12'd1], mem[mem_addr]};
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= pat(i);
            mem_ready <= 1'b1;
        end else if (mem_memW) begin
            mem[mem_addr]         <= mem_dataW[7:0];
            mem[mem_addr + 12'd1] <= mem_dataW[15:8];
            mem[mem_addr + 12'd2] <= mem_dataW[23:16];
            mem[mem_addr + 12'd3] <= mem_dataW[31:24];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  ref_mem [0:MEM_SIZE-1];
    int          busy_until = 0;
    bit          prio = 1'b0;
    bit          acc_v = 1'b0, acc_mst, acc_we;
    int          acc_cyc;
    logic [11:0] acc_addr;
    logic [31:0] acc_wdata;
    bit          rsp_v = 1'b0, rsp_mst, rsp_err;
    int          rsp_cyc;
    logic [31:0] rsp_data;

    // Driver state
    cmd_t        q0[$], q1[$];
    bit          act [2];
    bit          we_c [2];
    logic [11:0] addr_c [2];
    logic [31:0] wd_c [2];
    int          go_pct = 100, drop_pct = 0;

    // Observations
    int          rv_cnt [2];
    logic [31:0] last_rd [2];
    bit          glog[$];

    function automatic logic [31:0] ref_rd(input logic [11:0] a);
        logic [11:0] a1, a2, a3;
        a1 = a + 12'd1; a2 = a + 12'd2; a3 = a + 12'd3;
        return {ref_mem[a3], ref_mem[a2], ref_mem[a1], ref_mem[a]};
    endfunction

    task automatic ref_wr(input logic [11:0] a, input logic [31:0] d);
        ref_mem[a]         = d[7:0];
        ref_mem[a + 12'd1] = d[15:8];
        ref_mem[a + 12'd2] = d[23:16];
        ref_mem[a + 12'd3] = d[31:24];
    endtask

    task automatic drive();
        cmd_t c;
        for (int m = 0; m < 2; m++) begin
            if (act[m] && drop_pct > 0 && $urandom_range(0, 99) < drop_pct) act[m] = 1'b0;
            if (!act[m] && $urandom_range(0, 99) < go_pct) begin
                if (m == 0 && q0.size() > 0) begin
                    c = q0.pop_front(); act[0] = 1'b1;
                    we_c[0] = c.we; addr_c[0] = c.addr; wd_c[0] = c.wdata;
                end else if (m == 1 && q1.size() > 0) begin
                    c = q1.pop_front(); act[1] = 1'b1;
                    we_c[1] = c.we; addr_c[1] = c.addr; wd_c[1] = c.wdata;
                end
            end
        end
        m0_req   = act[0];
        m0_we    = act[0] ? we_c[0]   : 1'($urandom);
        m0_addr  = act[0] ? addr_c[0] : 12'($urandom);
        m0_wdata = act[0] ? wd_c[0]   : $urandom;
        m1_req   = act[1];
        m1_we    = act[1] ? we_c[1]   : 1'($urandom);
        m1_addr  = act[1] ? addr_c[1] : 12'($urandom);
        m1_wdata = act[1] ? wd_c[1]   : $urandom;
    endtask

    task automatic model_check();
        bit          e_g [2], e_rv [2], e_err [2];
        logic [31:0] e_rd [2];
        bit          e_mr, e_mw, acc_now, idle, w, misal;
        logic [11:0] e_addr;
        logic [31:0] e_dw;
        for (int m = 0; m < 2; m++) begin
            e_g[m] = 1'b0; e_rv[m] = 1'b0; e_err[m] = 1'b0; e_rd[m] = '0;
        end
        e_mr = 1'b0; e_mw = 1'b0; acc_now = 1'b0; idle = 1'b0; w = 1'b0; misal = 1'b0;
        e_addr = '0; e_dw = '0;
        if (!rst) begin
            if (rsp_v && rsp_cyc == cyc) begin
                e_rv[rsp_mst] = 1'b1; e_rd[rsp_mst] = rsp_data; e_err[rsp_mst] = rsp_err;
            end
            if (acc_v && acc_cyc == cyc) begin
                acc_now = 1'b1; e_mr = !acc_we; e_mw = acc_we; e_addr = acc_addr; e_dw = acc_wdata;
            end
            if (cyc >= busy_until) begin
                idle = 1'b1;
                w = (act[0] && act[1]) ? prio : act[1];
                if (act[0] || act[1]) e_g[w] = 1'b1;
            end
        end
        check("m0_gnt",    32'(m0_gnt),    32'(e_g[0]));
        check("m1_gnt",    32'(m1_gnt),    32'(e_g[1]));
        check("mem_memR",  32'(mem_memR),  32'(e_mr));
        check("mem_memW",  32'(mem_memW),  32'(e_mw));
        check("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
        check("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
        check("m0_rdata",  m0_rdata,       e_rd[0]);
        check("m1_rdata",  m1_rdata,       e_rd[1]);
`ifdef DMEM_ALIGN_CHECK_EN
        check("m0_err",    32'(m0_err),    32'(e_err[0]));
        check("m1_err",    32'(m1_err),    32'(e_err[1]));
`endif
        if (acc_now) begin
            check("mem_addr_access", 32'(mem_addr), 32'(e_addr));
            if (e_mw) check("mem_dataW_access", mem_dataW, e_dw);
        end
        if (idle) begin
            check("mem_addr_idle",  32'(mem_addr), 32'd0);
            check("mem_dataW_idle", mem_dataW,     32'd0);
        end
        for (int m = 0; m < 2; m++) begin
            if (m == 0 ? m0_rvalid : m1_rvalid) begin
                rv_cnt[m]++;
                last_rd[m] = (m == 0) ? m0_rdata : m1_rdata;
            end
        end
        if (m0_gnt) begin glog.push_back(1'b0); act[0] = 1'b0; end
        if (m1_gnt) begin glog.push_back(1'b1); act[1] = 1'b0; end
        if (rst) begin
            acc_v = 1'b0; rsp_v = 1'b0; prio = 1'b0; busy_until = cyc + 1;
        end else begin
            if (rsp_v && rsp_cyc == cyc) begin
                rsp_v = 1'b0;
                prio  = !rsp_mst;
            end
            if (acc_now) begin
                acc_v    = 1'b0;
                rsp_v    = 1'b1;
                rsp_cyc  = cyc + 1;
                rsp_mst  = acc_mst;
                rsp_err  = 1'b0;
                rsp_data = acc_we ? 32'd0 : ref_rd(acc_addr);
                if (acc_we) ref_wr(acc_addr, acc_wdata);
            end
            if (e_g[0] || e_g[1]) begin
`ifdef DMEM_ALIGN_CHECK_EN
                misal = (addr_c[w][1:0] != 2'b00);
`endif
                if (misal) begin
                    rsp_v = 1'b1; rsp_cyc = cyc + 1; rsp_mst = w;
                    rsp_data = '0; rsp_err = 1'b1;
                    busy_until = cyc + 2;
                end else begin
                    acc_v = 1'b1; acc_cyc = cyc + 1; acc_mst = w;
                    acc_we = we_c[w]; acc_addr = addr_c[w]; acc_wdata = wd_c[w];
                    busy_until = cyc + 3;
                end
            end
        end
    endtask

    task automatic step(input bit r);
        @(negedge clk);
        cyc++;
        rst = r;
        drive();
        #1;
        model_check();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !act[0] && !act[1] &&
                 !acc_v && !rsp_v && cyc >= busy_until) && n < budget) begin
            step(1'b0);
            n++;
        end
        check("idle_reached", 32'(n < budget), 32'd1);
    endtask

    task automatic push(input bit m, input bit we, input logic [11:0] a, input logic [31:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        if (m) q1.push_back(c);
        else   q0.push_back(c);
    endtask

    initial begin
        int rv0, rv1, n;
        bit seen;
        logic [11:0] a;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = pat(i);
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; we_c[m] = 1'b0; addr_c[m] = '0; wd_c[m] = '0;
            rv_cnt[m] = 0; last_rd[m] = '0;
        end
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (3) step(1'b1);

        // Write then read back through master 0
        push(1'b0, 1'b1, 12'h010, 32'hDEADBEEF);
        push(1'b0, 1'b0, 12'h010, 32'h0);
        run_until_idle(50);
        check("t1_readback", last_rd[0], 32'hDEADBEEF);
        $display("[TB] t1 write/read 0x010 rdata=%h", last_rd[0]);

        // Simultaneous requests from reset, both held: grants alternate starting with m0
        repeat (2) step(1'b1);
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b0, 12'(12'h040 + 4 * i), 32'h0);
            push(1'b1, 1'b0, 12'(12'h080 + 4 * i), 32'h0);
        end
        run_until_idle(100);
        check("t2_ngrants", 32'(glog.size()), 32'd8);
        for (int i = 0; i < glog.size() && i < 8; i++) check("t2_order", 32'(glog[i]), 32'(i % 2));
        $display("[TB] t2 alternating grants count=%0d", glog.size());

        // Lone master 1 served back-to-back
        glog.delete();
        rv0 = rv_cnt[0]; rv1 = rv_cnt[1];
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 12'(12'h100 + 4 * i), 32'h0);
        run_until_idle(100);
        check("t3_ngrants", 32'(glog.size()), 32'd4);
        check("t3_m1_rvalids", 32'(rv_cnt[1] - rv1), 32'd4);
        check("t3_m0_rvalids", 32'(rv_cnt[0] - rv0), 32'd0);
        $display("[TB] t3 lone m1 grants=%0d", glog.size());

        // Reset during the ACCESS cycle of a write aborts it
        push(1'b1, 1'b1, 12'h020, 32'h55667788);
        run_until_idle(50);
        push(1'b1, 1'b1, 12'h020, 32'h11223344);
        seen = 1'b0; n = 0;
        while (!seen && n < 20) begin
            step(1'b0);
            seen = m1_gnt;
            n++;
        end
        check("t4_gnt_seen", 32'(seen), 32'd1);
        rv1 = rv_cnt[1];
        step(1'b1);
        repeat (3) step(1'b0);
        check("t4_no_rvalid", 32'(rv_cnt[1] - rv1), 32'd0);
        push(1'b1, 1'b0, 12'h020, 32'h0);
        run_until_idle(50);
        check("t4_old_data", last_rd[1], 32'h55667788);
        $display("[TB] t4 reset mid-write readback=%h", last_rd[1]);

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned read returns an error without touching memory
        rv0 = rv_cnt[0];
        push(1'b0, 1'b0, 12'h013, 32'h0);
        run_until_idle(50);
        check("t5_rvalid", 32'(rv_cnt[0] - rv0), 32'd1);
        check("t5_rdata", last_rd[0], 32'd0);
        $display("[TB] t5 misaligned read rdata=%h", last_rd[0]);
`else
        // Write straddling the top of memory wraps onto address 0
        push(1'b0, 1'b1, 12'hFFE, 32'hA1B2C3D4);
        push(1'b0, 1'b0, 12'h000, 32'h0);
        run_until_idle(50);
        check("t6_wrap_low16", 32'(last_rd[0][15:0]), 32'h0000A1B2);
        $display("[TB] t6 wrapped read rdata=%h", last_rd[0]);
`endif

        // Randomized traffic with gaps and abandoned requests
        go_pct = 60; drop_pct = 5;
        for (int i = 0; i < 300; i++) begin
            a = 12'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) a = 12'(12'hFFC + $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
            push(1'(i % 2), 1'($urandom_range(0, 1)), a, $urandom);
        end
        run_until_idle(5000);
        $display("[TB] random phase done at cycle %0d", cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
